// File: rtl/reg_dump_reader.sv
// Debug readout engine: walks x1..LAST_IDX through the spare register-file read port and
// streams (index, data) beats on valid/ready. Optional REGDUMP_CHECKSUM_EN appends an XOR beat.
module reg_dump_reader #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int LAST_IDX = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   RdIdx,
    input  logic [XLEN-1:0] RdData,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_index,
    output logic [XLEN-1:0] out_data,
    output logic            out_last
);

    // state  | meaning
    // IDLE   | waiting for start, read port quiescent
    // READ   | RdIdx = counter, capture RdData into the beat registers
    // HOLD   | beat valid, waiting for out_ready
    // CSUM   | checksum beat valid (REGDUMP_CHECKSUM_EN only)
    // DONE   | one-cycle done pulse
`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_HOLD, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;
`endif

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;
    logic [AW-1:0]   rd_idx_q;
    logic [AW-1:0]   out_index_q;
    logic [XLEN-1:0] out_data_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            busy_q;
    logic            done_q;
    logic            is_last;

    assign cnt_d   = cnt_q + 1'b1;
    assign is_last = (cnt_q == AW'(LAST_IDX));

`ifdef REGDUMP_CHECKSUM_EN
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_d;
    assign acc_d = acc_q ^ out_data_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_idx_q    <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= S_READ;
                        cnt_q    <= AW'(1);
                        rd_idx_q <= AW'(1);
                        busy_q   <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                        acc_q    <= '0;
`endif
                    end
                end
                S_READ: begin
                    out_index_q <= cnt_q;
                    out_data_q  <= RdData;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last_q  <= 1'b0;
`else
                    out_last_q  <= is_last;
`endif
                    out_valid_q <= 1'b1;
                    rd_idx_q    <= '0;
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                        acc_q <= acc_d;
`endif
                        if (is_last) begin
`ifdef REGDUMP_CHECKSUM_EN
                            // checksum beat follows x31 directly, no read bubble needed
                            state_q     <= S_CSUM;
                            out_index_q <= '0;
                            out_data_q  <= acc_d;
                            out_last_q  <= 1'b1;
`else
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
`endif
                        end else begin
                            cnt_q       <= cnt_d;
                            rd_idx_q    <= cnt_d;
                            out_valid_q <= 1'b0;
                            state_q     <= S_READ;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign RdIdx     = rd_idx_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: scenario table plus random ready/register contents,
// checked against a per-dump expected beat list built from the register array.
module tb_reg_dump_reader;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int LAST_IDX = 31;
`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int NBEATS = CSUM ? 32 : 31;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [AW-1:0]   RdIdx;
    logic [XLEN-1:0] RdData;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_index;
    logic [XLEN-1:0] out_data;
    logic            out_last;

    logic [XLEN-1:0] regs [32];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic            last;
    } beat_t;

    typedef struct {
        int fill;         // 0 incrementing, 1 all ones, 2 zeros, 3 random
        int ready_pct;
        int stall_idx;    // -1 = none
        int stall_len;
        int restart_idx;  // -1 = none
        int reset_idx;    // -1 = none
        int exp_beats;
    } vec_t;

    always #5 clk = ~clk;

    assign RdData = (RdIdx == '0) ? '0 : regs[RdIdx];

    reg_dump_reader #(.XLEN(XLEN), .AW(AW), .LAST_IDX(LAST_IDX)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .RdIdx     (RdIdx),
        .RdData    (RdData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < 32; k++) begin
            case (mode)
                0:       regs[k] = 32'h1000_0000 + k;
                1:       regs[k] = '1;
                2:       regs[k] = '0;
                default: regs[k] = $urandom();
            endcase
        end
    endtask

    task automatic do_dump(input vec_t v, output int nbeats);
        beat_t           exp_q[$];
        beat_t           b;
        logic [XLEN-1:0] acc;
        logic [AW-1:0]   p_idx;
        logic [XLEN-1:0] p_data;
        logic            p_last;
        int              gap;
        int              stall_left;
        int              last_cyc;
        bit              prev_stall;
        bit              finished;

        acc = '0;
        nbeats = 0;
        last_cyc = -1;
        p_idx = '0;
        p_data = '0;
        p_last = 1'b0;
        for (int k = 1; k <= LAST_IDX; k++) begin
            exp_q.push_back('{idx: AW'(k), data: regs[k], last: (!CSUM && k == LAST_IDX)});
            acc ^= regs[k];
        end
        if (CSUM) exp_q.push_back('{idx: '0, data: acc, last: 1'b1});

        start = 1'b1;
        gap = 0;
        stall_left = 0;
        prev_stall = 1'b0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            gap++;
            chk("busy_in_dump", busy, 1);
            chk("no_early_done", done, 0);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_index", out_index, p_idx);
                chk("stall_data", out_data, p_data);
                chk("stall_last", out_last, p_last);
            end
            if (!out_valid) begin
                prev_stall = 1'b0;
                out_ready = 1'($urandom_range(1));
                if (gap == 1 && exp_q.size() > 0) chk("rdidx_read", RdIdx, exp_q[0].idx);
                else chk("rdidx_idle", RdIdx, 0);
            end else begin
                chk("rdidx_quiet", RdIdx, 0);
                if (!prev_stall && exp_q.size() > 0) begin
                    chk("beat_gap", gap, (exp_q[0].idx == '0) ? 1 : 2);
                    if (v.reset_idx == int'(out_index)) begin
                        out_ready = 1'b0;
                        reset = 1'b1;
                        @(negedge clk);
                        reset = 1'b0;
                        chk("rst_valid", out_valid, 0);
                        chk("rst_busy", busy, 0);
                        chk("rst_rdidx", RdIdx, 0);
                        chk("rst_done", done, 0);
                        chk("rst_index", out_index, 0);
                        chk("rst_data", out_data, 0);
                        chk("rst_last", out_last, 0);
                        repeat (5) begin
                            @(negedge clk);
                            chk("no_done_after_reset", done, 0);
                            chk("idle_after_reset", {out_valid, busy}, 0);
                        end
                        return;
                    end
                    if (v.stall_idx == int'(out_index)) stall_left = v.stall_len;
                    if (v.restart_idx == int'(out_index)) start = 1'b1;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = ($urandom_range(99) < v.ready_pct);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat: got index %0d expected no beat", out_index);
                        finished = 1'b1;
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_index", out_index, b.idx);
                        chk("beat_data", out_data, b.data);
                        chk("beat_last", out_last, b.last);
                        nbeats++;
                        gap = 0;
                        prev_stall = 1'b0;
                        if (exp_q.size() == 0) begin
                            finished = 1'b1;
                            last_cyc = cyc;
                        end
                    end
                end else begin
                    prev_stall = 1'b1;
                    p_idx = out_index;
                    p_data = out_data;
                    p_last = out_last;
                    // already captured; changing it must not disturb the held beat
                    if (out_index != '0) regs[out_index] = $urandom();
                end
            end
        end

        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout: dump incomplete, got %0d beats expected %0d", nbeats, NBEATS);
            out_ready = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        if (v.ready_pct == 100 && v.stall_len == 0)
            chk("dump_cycles", last_cyc, 61 + (CSUM ? 1 : 0));
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        chk("valid_in_done", out_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("done_cleared", done, 0);
            chk("busy_cleared", busy, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_rdidx", RdIdx, 0);
        end
    endtask

    initial begin
        vec_t vecs[10];
        int   nb;

        vecs[0] = '{fill: 0, ready_pct: 100, stall_idx: -1, stall_len: 0, restart_idx: -1, reset_idx: -1, exp_beats: NBEATS};
        vecs[1] = '{fill: 0, ready_pct: 100, stall_idx: 7,  stall_len: 5, restart_idx: -1, reset_idx: -1, exp_beats: NBEATS};
        vecs[2] = '{fill: 0, ready_pct: 100, stall_idx: -1, stall_len: 0, restart_idx: 3,  reset_idx: -1, exp_beats: NBEATS};
        vecs[3] = '{fill: 0, ready_pct: 100, stall_idx: -1, stall_len: 0, restart_idx: -1, reset_idx: 12, exp_beats: 11};
        vecs[4] = '{fill: 1, ready_pct: 100, stall_idx: -1, stall_len: 0, restart_idx: -1, reset_idx: -1, exp_beats: NBEATS};
        vecs[5] = '{fill: 2, ready_pct: 100, stall_idx: -1, stall_len: 0, restart_idx: -1, reset_idx: -1, exp_beats: NBEATS};
        vecs[6] = '{fill: 3, ready_pct: 50,  stall_idx: -1, stall_len: 0, restart_idx: -1, reset_idx: -1, exp_beats: NBEATS};
        vecs[7] = '{fill: 3, ready_pct: 30,  stall_idx: 31, stall_len: 3, restart_idx: 20, reset_idx: -1, exp_beats: NBEATS};
        vecs[8] = '{fill: 3, ready_pct: 80,  stall_idx: 1,  stall_len: 2, restart_idx: -1, reset_idx: -1, exp_beats: NBEATS};
        vecs[9] = '{fill: 1, ready_pct: 60,  stall_idx: -1, stall_len: 0, restart_idx: -1, reset_idx: -1, exp_beats: NBEATS};

        fill(0);
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rdidx", RdIdx, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_index", out_index, 0);
        chk("reset_data", out_data, 0);
        chk("reset_last", out_last, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_start", busy, 0);

        for (int v = 0; v < 10; v++) begin
            fill(vecs[v].fill);
            do_dump(vecs[v], nb);
            chk("beat_count", nb, vecs[v].exp_beats);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Debug readout engine for the 31-entry integer register file (x1..x31; x0 reads as zero).
- On a start pulse, walks the register file's spare read port through x1..x31 and captures each value.
- Streams each (index, data) beat out on a valid/ready interface to the debug/trace path.
- It is the reader-side counterpart to the core's register write path and never writes the register file.

Parameters:
XLEN, 32, register data width
AW, 5, register index width
LAST_IDX, 31, highest register index dumped (first index is fixed at 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
start  input  1  request a full dump; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted until DONE is exited
done  output  1  one-cycle pulse when the dump completes
RdIdx  output  AW  index driven to the register file read port
RdData  input  XLEN  combinational read data returned for RdIdx, same cycle
out_valid  output  1  beat available
out_ready  input  1  consumer accepts beat
out_index  output  AW  register index of current beat
out_data  output  XLEN  register value of current beat
out_last  output  1  marks final beat of the dump

Behaviour:
- States and transitions:
  - IDLE -> READ on start; index counter loads 1.
  - READ: RdIdx = counter; RdData, counter and last flag registered into the out_* registers; -> HOLD.
  - HOLD: out_valid = 1. On out_valid & out_ready: if the beat was last -> DONE, else counter + 1 and -> READ.
  - DONE: done = 1 for exactly one cycle, then -> IDLE.
- Reset values: state IDLE, counter 0, RdIdx 0, out_valid 0, out_index 0, out_data 0, out_last 0, busy 0, done 0.
- RdIdx outside READ is held at 0 so the read port is quiescent.
- Timing:
  - start high in cycle N (IDLE) -> READ in cycle N+1 with RdIdx = 1 -> out_valid in cycle N+2.
  - Throughput: 2 cycles per beat minimum (READ bubble after every transfer).
  - Full dump with out_ready tied high: 62 cycles from first READ to the last transfer, then DONE.
- Stability: while out_valid & !out_ready, out_index, out_data and out_last hold constant.
  - Register file changes during HOLD are not reflected in the held beat.
- Data is a snapshot per beat, not per dump; concurrent core writes may be visible in later beats.
- start is ignored in READ, HOLD and DONE; it is not queued.
- Counter never exceeds LAST_IDX and never wraps; x0 is never emitted as a register beat.
- out_last = 1 only on the x31 beat (see Optional Feature).
- Reset asserted in any state -> next cycle IDLE with all reset values.
  - An in-flight beat is dropped and done does not pulse.

Optional Feature:
Macro REGDUMP_CHECKSUM_EN.
- Defined:
  - A 32-bit XOR accumulator clears on start acceptance.
  - The accumulator XORs out_data on every transferred register beat.
  - The x31 beat has out_last = 0.
  - After the x31 transfer, state CSUM presents an extra beat: out_index = 0, out_data = accumulator value including x31, out_last = 1.
  - Transfer of that beat -> DONE.
  - Dump is 32 beats.
- Not defined: no accumulator and no CSUM state; the x31 beat carries out_last = 1; dump is 31 beats.

Test Plan:
- Preload xk = 0x1000_0000 + k, out_ready = 1, pulse start -> 31 beats, indices 1..31 in order, data 0x1000_0001..0x1000_001F, out_last only on index 31, done one cycle after the last transfer, busy low the cycle after done.
- out_ready low for 5 cycles while the index 7 beat is valid -> index and data held constant all 5 cycles; index 8 appears 2 cycles after the transfer.
- start pulsed again in the cycle with the index 3 beat valid -> ignored; exactly one dump of 31 beats; start after done accepted -> new dump begins at index 1.
- reset asserted in HOLD at index 12 -> next cycle out_valid = 0, busy = 0, RdIdx = 0, no done pulse; a later start emits index 1 first.
- With REGDUMP_CHECKSUM_EN, all registers = 0xFFFF_FFFF -> 32 beats, x31 beat out_last = 0, final beat index 0 with data 0xFFFF_FFFF (31 odd) and out_last = 1.
- Without the macro, all registers zero -> 31 beats of 0x0000_0000, last at index 31, no index-0 beat.
